// File: rtl/decode_dispatch_ctrl_if.sv
// Fetch-to-decode handshake bundle for the dispatch buffer.
// The master side is the fetch/decode environment; the slave side is the buffer.
interface decode_dispatch_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic [1:0]    in_valid;
  logic [31:0]   in_instr0;
  logic [31:0]   in_instr1;
  logic [31:0]   in_pc;
  logic          in_ready;
  logic          dec_ready;
  logic          dec_valid;
  logic          dec_slot2_valid;
  logic [31:0]   dec_instr1;
  logic [31:0]   dec_instr2;
  logic [31:0]   dec_pc1;
  logic [31:0]   dec_pc2;
  logic [CW-1:0] count;

  modport master (
    output flush, in_valid, in_instr0, in_instr1, in_pc, dec_ready,
    input  in_ready, dec_valid, dec_slot2_valid, dec_instr1, dec_instr2,
           dec_pc1, dec_pc2, count
  );

  modport slave (
    input  flush, in_valid, in_instr0, in_instr1, in_pc, dec_ready,
    output in_ready, dec_valid, dec_slot2_valid, dec_instr1, dec_instr2,
           dec_pc1, dec_pc2, count
  );
endinterface

// File: rtl/decode_dispatch_ctrl.sv
// Two-wide instruction buffer between fetch and decode. Dispatches up to two
// instructions per cycle in program order and keeps memory ops to one per group.
module decode_dispatch_ctrl #(
  parameter int          DEPTH       = 8,
  parameter bit          MEM_PAIR_EN = 1'b0,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset_n,
  decode_dispatch_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_plus1;
  logic [AW-1:0] tail_plus1;
  logic [CW-1:0] count_q;
  logic [1:0]    npush;
  logic [1:0]    npop;
  logic          grp_valid;
  logic          pair;
  logic          slot2;

  function automatic logic is_mem(input logic [31:0] x);
    return (x[6:0] == 7'b0000011) || (x[6:0] == 7'b0100011);
  endfunction

  // Only one LSU port downstream, so two memory ops never share a group
  // unless the parameter explicitly allows it.
  always_comb begin
    head_plus1   = head + AW'(1);
    tail_plus1   = tail + AW'(1);
    bus.in_ready = (count_q <= CW'(DEPTH - 2));
    npush        = 2'd0;
    if (bus.in_ready && !bus.flush) begin
      if (bus.in_valid == 2'b11)
        npush = 2'd2;
      else if (bus.in_valid == 2'b01)
        npush = 2'd1;
    end
    grp_valid = (count_q != '0) && !bus.flush;
    pair      = (count_q >= CW'(2)) &&
                (MEM_PAIR_EN || !(is_mem(instr_q[head]) && is_mem(instr_q[head_plus1])));
    slot2     = grp_valid && pair;
    npop      = 2'd0;
    if (grp_valid && bus.dec_ready)
      npop = slot2 ? 2'd2 : 2'd1;

    bus.dec_valid       = grp_valid;
    bus.dec_slot2_valid = slot2;
    bus.dec_instr1      = grp_valid ? instr_q[head] : NOP_INSTR;
    bus.dec_pc1         = grp_valid ? pc_q[head] : 32'd0;
    bus.dec_instr2      = slot2 ? instr_q[head_plus1] : NOP_INSTR;
    bus.dec_pc2         = slot2 ? pc_q[head_plus1] : 32'd0;
    bus.count           = count_q;
  end

  // Flush wins over everything else so no stale entry can survive a redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= NOP_INSTR;
        pc_q[i]    <= 32'd0;
      end
    end else if (bus.flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (npush != 2'd0) begin
        instr_q[tail] <= bus.in_instr0;
        pc_q[tail]    <= bus.in_pc;
      end
      if (npush == 2'd2) begin
        instr_q[tail_plus1] <= bus.in_instr1;
        pc_q[tail_plus1]    <= bus.in_pc + 32'd4;
      end
      tail    <= tail + AW'(npush);
      head    <= head + AW'(npop);
      count_q <= count_q + CW'(npush) - CW'(npop);
    end
  end
endmodule
